// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// Holds the bus request/response structs and the arbiter register record.
package mem_port_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_type;

  typedef struct packed {
    arb_state_type state;
    mem_in_type    islot;
    mem_in_type    dslot;
    logic          iocc;
    logic          docc;
    logic          last_d;
    logic          drop;
  } arb_reg_type;

  // last_d starts opposite to the preferred side so round-robin picks it first.
  function automatic arb_reg_type init_arb_reg(input logic data_first);
    arb_reg_type t;
    t        = '0;
    t.state  = IDLE;
    t.last_d = ~data_first;
    return t;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction and data requesters, one transaction outstanding.
// Uncontended request issues combinationally in its valid cycle; responses pass through with zero added latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1,
  parameter bit RR_ENABLE  = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        iflush,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  arb_reg_type r, rin;

  always_comb begin
    arb_reg_type v;
    mem_in_type  ireq;
    mem_in_type  dreq;
    logic        grant_d;

    v        = r;
    imem_out = '0;
    dmem_out = '0;
    mem_in   = '0;
    grant_d  = 1'b0;
    ireq     = imem_in;
    ireq.mem_valid = 1'b0;
    dreq     = dmem_in;
    dreq.mem_valid = 1'b0;

    // Slot capture: latest valid wins; a side with its request on the bus ignores new valids.
    if (r.state != BUSY_I) begin
      if (iflush) begin
        v.iocc = 1'b0;
      end else if (imem_in.mem_valid) begin
        v.islot = ireq;
        v.iocc  = 1'b1;
      end
    end else if (iflush) begin
      v.drop = 1'b1;
    end

    if (r.state != BUSY_D && dmem_in.mem_valid) begin
      v.dslot = dreq;
      v.docc  = 1'b1;
    end

    case (r.state)
      IDLE: begin
        if (v.iocc && v.docc) begin
          grant_d  = RR_ENABLE ? ~r.last_d : DATA_FIRST;
          v.last_d = grant_d;
        end else begin
          grant_d = v.docc;
        end
        if (v.iocc || v.docc) begin
          mem_in           = grant_d ? v.dslot : v.islot;
          mem_in.mem_valid = 1'b1;
          v.state          = grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I: begin
        mem_in = r.islot;
        if (mem_out.mem_ready) begin
          imem_out.mem_ready = ~v.drop;
          imem_out.mem_rdata = v.drop ? 32'h0 : mem_out.mem_rdata;
          v.iocc  = 1'b0;
          v.drop  = 1'b0;
          v.state = IDLE;
        end
      end
      BUSY_D: begin
        mem_in = r.dslot;
        if (mem_out.mem_ready) begin
          dmem_out.mem_ready = 1'b1;
          dmem_out.mem_rdata = mem_out.mem_rdata;
          v.docc  = 1'b0;
          v.state = IDLE;
        end
      end
      default: v.state = IDLE;
    endcase

    // Outputs are combinational, so hold them quiet while reset is asserted.
    if (!rst) begin
      mem_in   = '0;
      imem_out = '0;
      dmem_out = '0;
    end

    rin = v;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r <= init_arb_reg(DATA_FIRST);
    else      r <= rin;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected bus requests and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iflush;
  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    mem_in_type req;
    int         at;
  } bus_exp_t;

  bus_exp_t    bq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  mem_port_arbiter dut (
    .rst(rst), .clk(clk), .iflush(iflush),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  initial begin
    bus_exp_t    e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mem_in.mem_valid) begin
        if (bq.size() == 0) check("bus_unexpected", 96'(mem_in), 96'(0));
        else begin
          e = bq.pop_front();
          check("bus_req", 96'(mem_in), 96'(e.req));
          check("bus_cycle", 96'(cyc), 96'(e.at));
        end
      end
      if (imem_out.mem_ready) begin
        if (iq.size() == 0) check("imem_unexpected", 96'(imem_out), 96'(0));
        else begin
          d = iq.pop_front();
          check("imem_rdata", 96'(imem_out.mem_rdata), 96'(d));
        end
      end
      if (dmem_out.mem_ready) begin
        if (dq.size() == 0) check("dmem_unexpected", 96'(dmem_out), 96'(0));
        else begin
          d = dq.pop_front();
          check("dmem_rdata", 96'(dmem_out.mem_rdata), 96'(d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    imem_in = '0;
    dmem_in = '0;
    iflush  = 1'b0;
    mem_out = '0;
  endtask

  function automatic mem_in_type mk(input logic instr, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] ws, input logic f);
    mem_in_type m;
    m = '0;
    m.mem_valid = 1'b1;
    m.mem_instr = instr;
    m.mem_addr  = a;
    m.mem_wdata = wd;
    m.mem_wstrb = ws;
    m.mem_fence = f;
    return m;
  endfunction

  task automatic ireq(input logic [31:0] a);
    imem_in = mk(1'b1, a, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic dreq(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic f);
    dmem_in = mk(1'b0, a, wd, ws, f);
  endtask

  task automatic exp_bus(input mem_in_type m, input int at);
    bus_exp_t e;
    e.req = m;
    e.at  = at;
    bq.push_back(e);
  endtask

  task automatic respond(input logic [31:0] d);
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = d;
    tick();
    mem_out = '0;
  endtask

  initial begin
    int c;
    idle_in();

    // 1. Reset: quiet outputs, reset mid-BUSY_D, first request after release issues at once
    #3;
    check("rst_mem_in", 96'(mem_in), 96'(0));
    check("rst_imem_out", 96'(imem_out), 96'(0));
    check("rst_dmem_out", 96'(dmem_out), 96'(0));
    tick(); tick();
    rst = 1'b1;
    tick();
    dreq(32'h50, 32'h0, 4'h0, 1'b0);
    exp_bus(mk(1'b0, 32'h50, 32'h0, 4'h0, 1'b0), cyc);
    tick(); idle_in();
    tick();
    rst = 1'b0;
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'hFFFF;
    #1;
    check("midrst_mem_in", 96'(mem_in), 96'(0));
    check("midrst_dmem_out", 96'(dmem_out), 96'(0));
    check("midrst_imem_out", 96'(imem_out), 96'(0));
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    dreq(32'h100, 32'h0, 4'h0, 1'b0);
    exp_bus(mk(1'b0, 32'h100, 32'h0, 4'h0, 1'b0), cyc);
    #1;
    check("post_rst_issue", 96'(mem_in.mem_valid), 96'(1));
    tick(); idle_in();
    tick();
    dq.push_back(32'h11);
    respond(32'h11);

    // 2. Lone fetch, bus ready three cycles after issue
    c = cyc;
    ireq(32'h8000_0000);
    exp_bus(mk(1'b1, 32'h8000_0000, 32'h0, 4'h0, 1'b0), c);
    tick(); idle_in();
    tick(); tick();
    iq.push_back(32'h13);
    respond(32'h13);

    // 3. Conflicts: data wins first, then instruction wins the repeat
    c = cyc;
    ireq(32'h200);
    dreq(32'h400, 32'h0, 4'h0, 1'b0);
    exp_bus(mk(1'b0, 32'h400, 32'h0, 4'h0, 1'b0), c);
    exp_bus(mk(1'b1, 32'h200, 32'h0, 4'h0, 1'b0), c + 3);
    tick(); idle_in();
    tick();
    dq.push_back(32'h4444);
    respond(32'h4444);
    tick();
    iq.push_back(32'h2222);
    respond(32'h2222);

    c = cyc;
    ireq(32'h300);
    dreq(32'h500, 32'h0, 4'h0, 1'b0);
    exp_bus(mk(1'b1, 32'h300, 32'h0, 4'h0, 1'b0), c);
    exp_bus(mk(1'b0, 32'h500, 32'h0, 4'h0, 1'b0), c + 3);
    tick(); idle_in();
    tick();
    iq.push_back(32'h3333);
    respond(32'h3333);
    tick();
    dq.push_back(32'h5555);
    respond(32'h5555);

    // 4. Pending instruction slot overwritten while data is in flight
    c = cyc;
    dreq(32'h600, 32'h0, 4'h0, 1'b0);
    exp_bus(mk(1'b0, 32'h600, 32'h0, 4'h0, 1'b0), c);
    exp_bus(mk(1'b1, 32'h204, 32'h0, 4'h0, 1'b0), c + 4);
    tick(); idle_in(); ireq(32'h200);
    tick(); ireq(32'h204);
    tick(); idle_in();
    dq.push_back(32'h6666);
    respond(32'h6666);
    tick();
    iq.push_back(32'h2040);
    respond(32'h2040);

    // 5. Flush while the fetch is on the bus; the queued data request follows
    c = cyc;
    ireq(32'h700);
    exp_bus(mk(1'b1, 32'h700, 32'h0, 4'h0, 1'b0), c);
    exp_bus(mk(1'b0, 32'h800, 32'h0, 4'h0, 1'b0), c + 4);
    tick(); idle_in();
    dreq(32'h800, 32'h0, 4'h0, 1'b0);
    iflush = 1'b1;
    tick(); idle_in();
    tick();
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'h77;
    #1;
    check("flush_imem_ready", 96'(imem_out.mem_ready), 96'(0));
    tick(); idle_in();
    tick();
    dq.push_back(32'h88);
    respond(32'h88);

    // 6. Store fields pass through; a flushed pending fetch never reaches the bus
    c = cyc;
    dreq(32'h900, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    exp_bus(mk(1'b0, 32'h900, 32'hDEAD_BEEF, 4'b0011, 1'b1), c);
    tick(); idle_in(); ireq(32'hA00);
    tick(); idle_in(); iflush = 1'b1;
    tick(); idle_in();
    dq.push_back(32'h5A);
    respond(32'h5A);
    tick();
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'hBAD;
    tick(); idle_in();
    tick(); tick(); tick();

    check("bus_queue_drained", 96'(bq.size()), 96'(0));
    check("imem_queue_drained", 96'(iq.size()), 96'(0));
    check("dmem_queue_drained", 96'(dq.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
